mul_iter: RTL
=============

# mul_iter

Iterative radix-2 shift-and-add multiplier for the RV64M multiply group (MUL, MULH, MULHSU, MULHU) in the NPC execute stage. It takes operands from the issue/ALU dispatch through a valid/ready handshake and retires one partial product per cycle through a 65-bit accumulate adder. It returns the selected 64-bit half of the product to writeback through a second valid/ready handshake. The block keeps one operation in flight and supports a pipeline flush.

## Interface
- XLEN, 64, operand and result width; the accumulator is XLEN+1 bits and the product register is 2*XLEN bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  kills any in-flight operation; synchronous.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  high only in IDLE.
- mul_op  in  2  00 MUL (low half), 01 MULH (s×s, high), 10 MULHSU (rs1 signed × rs2 unsigned, high), 11 MULHU (u×u, high).
- src1  in  XLEN  rs1 value.
- src2  in  XLEN  rs2 value.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  selected product half.

## Operation
- States and transitions:
  - IDLE → BUSY when in_valid && in_ready && !flush.
  - BUSY → BUSY while cnt != XLEN-1, then → FIX.
  - FIX → DONE.
  - DONE → IDLE when out_valid && out_ready.
- Flush from any state returns the block to IDLE on the next edge. If flush is high in IDLE together with in_valid, the request is not accepted (flush wins).
- Accept (on the handshake edge):
  - Latch mcand = |src1| when src1 is signed-interpreted, otherwise src1 unchanged.
  - Latch mplier = |src2| by the same rule.
  - Latch neg = sign1 XOR sign2, where signN is the MSB only if that operand is signed for mul_op. MUL uses the unsigned path; its low half is sign-independent.
  - Latch op. Set acc = 0 and cnt = 0.
- Magnitude rule: |−2^63| = 2^63 and fits unsigned in XLEN. The product magnitude is at most 2^126 for signed pairs and below 2^128 otherwise, so the 128-bit product never overflows.
- Each BUSY cycle:
  - sum[XLEN:0] = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : 0).
  - {acc, mplier} <= {sum, mplier[XLEN-1:1]} >> 0, i.e. the 2*XLEN+1-bit concatenation shifts right by one.
  - cnt <= cnt + 1.
  - After XLEN iterations, {acc, mplier} holds the 128-bit magnitude.
- FIX:
  - prod <= neg ? (~{acc, mplier} + 1) : {acc, mplier}.
  - res_q <= (op == MUL) ? prod_low : prod_high, computed from the same fixup value.
- DONE: out_valid = 1 and result = res_q. Both hold stable while out_ready is low.
- Reset values: state IDLE, out_valid 0, result 0, in_ready 0 during reset and 1 in the first cycle after reset deasserts, cnt 0, acc 0.
- Reset asserted mid-operation behaves like flush: return to IDLE with no result produced.

## Timing
- Acceptance edge T0. BUSY covers edges T0+1..T0+64, FIX is edge T0+65, and out_valid is high in the cycle after edge T0+65. Total latency is 66 cycles.
- Earliest next acceptance is the cycle after the output handshake, because in_ready is low in DONE. Throughput is 1 op per 67 cycles when out_ready is held high.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid. Outputs depend on registered state only.
- The critical path is the 65-bit accumulate add in BUSY. The 128-bit negate is isolated in FIX.

## Structure
- Package mul_pkg holds:
  - XLEN.
  - The mul_op_e enum: MUL, MULH, MULHSU, MULHU.
  - The mul_state_e enum: IDLE, BUSY, FIX, DONE.
  - Helper constant CNT_W = $clog2(XLEN).
- Sub-module mul_acc_add is a parameterised (XLEN+1)-bit adder: inputs a, b; output sum. It has no carry-in and no registers.
- Everything else stays in mul_iter.

## Test plan
- MUL 3 × 5: in_valid is high for one cycle, and out_valid rises exactly 66 cycles later with result = 15. The next request is accepted the cycle after the output handshake.
- MULH −1 × −1: result = 0. The same operands with MUL give result = 1.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF: result = 0xFFFF_FFFF_FFFF_FFFE. MULHSU −1 × 0xFFFF_FFFF_FFFF_FFFF: result = 0xFFFF_FFFF_FFFF_FFFF.
- MULH 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000: result = 0x4000_0000_0000_0000. The same operands with MUL give result = 0.
- Backpressure: MUL 7 × 9 with out_ready held low for 10 cycles after out_valid. result stays 63 and in_ready stays low throughout; the transaction completes on the first out_ready.
- Flush at BUSY cycle 30, and separately rst_n = 0 at BUSY cycle 30: IDLE on the next edge, out_valid never rises for the killed op. A following MUL 2 × 2 returns 4 after 66 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the iterative RV64M
//                multiplier (operation select, FSM states, widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/mul_acc_add.sv
`default_nettype none
// ============================================================================
//  Module      : mul_acc_add
//  Description : Plain combinational adder used for the partial-product
//                accumulate step. No carry-in, no carry-out, no state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_acc_add #(
    parameter int WIDTH = 65
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
//                Operands are converted to magnitudes on accept, one partial
//                product is retired per cycle, and the sign is restored in a
//                dedicated FIX cycle so the 128-bit negate stays off the
//                accumulate path.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      mul_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);

    mul_state_e         r_state;
    mul_op_e            r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic               r_neg;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_result;

    mul_op_e            w_op_in;
    logic               w_sign1;
    logic               w_sign2;
    logic [XLEN-1:0]    w_mag1;
    logic [XLEN-1:0]    w_mag2;
    logic [XLEN:0]      w_addend;
    logic [XLEN:0]      w_sum;
    logic [2*XLEN-1:0]  w_fix;

    // Decode the operand signedness and take magnitudes at the input boundary
    always_comb begin
        w_op_in  = mul_op_e'(mul_op);
        w_sign1  = src1[XLEN-1] && ((w_op_in == MULH) || (w_op_in == MULHSU));
        w_sign2  = src2[XLEN-1] && (w_op_in == MULH);
        // -(-2^63) wraps to 2^63, which is still the right unsigned magnitude
        w_mag1   = w_sign1 ? (~src1 + 1'b1) : src1;
        w_mag2   = w_sign2 ? (~src2 + 1'b1) : src2;
        w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
        w_fix    = r_neg ? (~{r_acc, r_mplier} + 1'b1) : {r_acc, r_mplier};
    end

    mul_acc_add #(
        .WIDTH (XLEN + 1)
    ) u_acc_add (
        .a   ({1'b0, r_acc}),
        .b   (w_addend),
        .sum (w_sum)
    );

    // Control FSM and datapath registers; all outputs come straight from flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= MUL;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_mcand    <= w_mag1;
                        r_mplier   <= w_mag2;
                        r_neg      <= w_sign1 ^ w_sign2;
                        r_op       <= w_op_in;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    // {acc, mplier} shifts right by one with the new sum on top
                    r_acc    <= w_sum[XLEN:1];
                    r_mplier <= {w_sum[0], r_mplier[XLEN-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result    <= (r_op == MUL) ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire
